// File: rtl/mult_arbiter_ctrl.sv
// Shares one external 4x4 combinational multiplier between two requesters.
// Define MULT_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties) instead of round-robin.
//
// state  | meaning
// IDLE   | arbitrate; accept one request
// SETTLE | operands held on the multiplier while cnt counts down
// RESP   | product presented until the consumer takes it
module mult_arbiter_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_p,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_p,
  input  logic       rsp_ready
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] mul_a_q, mul_a_d;
  logic [3:0] mul_b_q, mul_b_d;
  logic [7:0] rsp_p_q, rsp_p_d;
  logic       rsp_id_q, rsp_id_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       grant;
  logic       accept;

`ifdef MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = req1_valid && !req0_valid;
  end
`else
  logic last_grant_q, last_grant_d;

  // On a tie the requester not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end
`endif

  assign req0_ready = (state_q == IDLE) && rst_n && !grant && req0_valid;
  assign req1_ready = (state_q == IDLE) && rst_n &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
`ifndef MULT_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          mul_a_d  = grant ? req1_a : req0_a;
          mul_b_d  = grant ? req1_b : req0_b;
          rsp_id_d = grant;
          cnt_d    = SETTLE_M1;
          state_d  = SETTLE;
`ifndef MULT_ARB_FIXED_PRIO_EN
          last_grant_d = grant;
`endif
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          rsp_p_d     = mul_p;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mul_a_q     <= 4'd0;
      mul_b_q     <= 4'd0;
      rsp_p_q     <= 8'd0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifndef MULT_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
`ifndef MULT_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_mult_arbiter_ctrl.sv
// Directed bench for mult_arbiter_ctrl: one instance with settle time 1, one with 4.
// Expected tie winners follow MULT_ARB_FIXED_PRIO_EN when it is defined.
module tb_mult_arbiter_ctrl;

  localparam int S1 = 1;
  localparam int S4 = 4;

  logic clk, rst_n;
  int   total, bad, cyc;

  logic       r0v, r1v, r0r, r1r, rspv, rspid, rsprdy;
  logic [3:0] r0a, r0b, r1a, r1b, ma, mb;
  logic [7:0] mp, rspp;

  logic       r0v4, r1v4, r0r4, r1r4, rspv4, rspid4, rsprdy4;
  logic [3:0] r0a4, r0b4, r1a4, r1b4, ma4, mb4;
  logic [7:0] mp4, rspp4;

  // Behavioural stand-in for the external multiplier
  assign mp  = {4'b0, ma}  * {4'b0, mb};
  assign mp4 = {4'b0, ma4} * {4'b0, mb4};

  mult_arbiter_ctrl #(.SETTLE_CYCLES(S1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(r0r),
    .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(r1r),
    .mul_a(ma), .mul_b(mb), .mul_p(mp),
    .rsp_valid(rspv), .rsp_id(rspid), .rsp_p(rspp), .rsp_ready(rsprdy)
  );

  mult_arbiter_ctrl #(.SETTLE_CYCLES(S4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v4), .req0_a(r0a4), .req0_b(r0b4), .req0_ready(r0r4),
    .req1_valid(r1v4), .req1_a(r1a4), .req1_b(r1b4), .req1_ready(r1r4),
    .mul_a(ma4), .mul_b(mb4), .mul_p(mp4),
    .rsp_valid(rspv4), .rsp_id(rspid4), .rsp_p(rspp4), .rsp_ready(rsprdy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation on the S=1 instance, starting in IDLE with rsp_ready high.
  task automatic op1(input logic sel, input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
    if (sel) begin r1v = 1'b1; r1a = a; r1b = b; end
    else     begin r0v = 1'b1; r0a = a; r0b = b; end
    #1;
    check("op1_ready0", r0r, !sel);
    check("op1_ready1", r1r, sel);
    tick();
    r0v = 1'b0; r1v = 1'b0;
    check("op1_mul_a", ma, a);
    check("op1_mul_b", mb, b);
    for (int i = 0; i < S1; i++) begin
      check("op1_settle_valid", rspv, 0);
      tick();
    end
    check("op1_rsp_valid", rspv, 1);
    check("op1_rsp_p", rspp, p);
    check("op1_rsp_id", rspid, sel);
    tick();
    check("op1_back_idle", rspv, 0);
  endtask

  task automatic op4(input logic sel, input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
    if (sel) begin r1v4 = 1'b1; r1a4 = a; r1b4 = b; end
    else     begin r0v4 = 1'b1; r0a4 = a; r0b4 = b; end
    #1;
    check("op4_ready", sel ? r1r4 : r0r4, 1);
    tick();
    r0v4 = 1'b0; r1v4 = 1'b0;
    for (int i = 0; i < S4; i++) begin
      if (rspv4 !== 1'b0) check("op4_settle_valid", rspv4, 0);
      tick();
    end
    check("op4_rsp_p", rspp4, p);
    if (rspv4 !== 1'b1 || rspid4 !== sel) begin
      check("op4_rsp_valid", rspv4, 1);
      check("op4_rsp_id", rspid4, sel);
    end
    tick();
  endtask

  initial begin
    logic       exp_win;
    int         last_acc;
    logic [7:0] prod;

    total = 0; bad = 0; cyc = 0;
    vecs[0] = '{1'b0, 4'd3,  4'd5,  8'd15};
    vecs[1] = '{1'b1, 4'd9,  4'd7,  8'd63};
    vecs[2] = '{1'b0, 4'd15, 4'd15, 8'd225};
    vecs[3] = '{1'b1, 4'd0,  4'd7,  8'd0};
    vecs[4] = '{1'b0, 4'd1,  4'd1,  8'd1};
    vecs[5] = '{1'b1, 4'd15, 4'd1,  8'd15};

    rst_n = 1'b0; rsprdy = 1'b1; rsprdy4 = 1'b1;
    r0v = 1'b1; r0a = 4'd3; r0b = 4'd3; r1v = 1'b1; r1a = 4'd0; r1b = 4'd0;
    r0v4 = 1'b0; r0a4 = 4'd0; r0b4 = 4'd0; r1v4 = 1'b0; r1a4 = 4'd0; r1b4 = 4'd0;
    #12;
    check("rst_ready0", r0r, 0);
    check("rst_ready1", r1r, 0);
    check("rst_rsp_valid", rspv, 0);
    check("rst_mul_a", ma, 0);
    check("rst_mul_b", mb, 0);
    check("rst_rsp_p", rspp, 0);
    check("rst_rsp_id", rspid, 0);
    r0v = 1'b0; r1v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table of isolated single-requester operations
    for (int i = 0; i < 6; i++) op1(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].p);

    // Both valid continuously; last winner above was req1
    r0a = 4'd9;  r0b = 4'd7;  r1a = 4'd15; r1b = 4'd15;
    r0v = 1'b1;  r1v = 1'b1;
    exp_win = 1'b0;
    last_acc = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tie_ready0", r0r, !exp_win);
      check("tie_ready1", r1r, exp_win);
      if (k > 0) check("tie_spacing", cyc - last_acc, S1 + 2);
      last_acc = cyc;
      tick();
      for (int i = 0; i < S1; i++) begin
        check("tie_busy_ready", {r0r, r1r}, 0);
        tick();
      end
      check("tie_rsp_valid", rspv, 1);
      check("tie_rsp_id", rspid, exp_win);
      check("tie_rsp_p", rspp, exp_win ? 8'd225 : 8'd63);
      tick();
`ifdef MULT_ARB_FIXED_PRIO_EN
      exp_win = 1'b0;
`else
      exp_win = ~exp_win;
`endif
    end
    r0v = 1'b0; r1v = 1'b0;

    // Back-pressure with req1 waiting
    r0v = 1'b1; r0a = 4'd4; r0b = 4'd6;
    #1;
    check("bp_accept0", r0r, 1);
    tick();
    r0v = 1'b0;
    r1v = 1'b1; r1a = 4'd5; r1b = 4'd5;
    for (int i = 0; i < S1; i++) tick();
    rsprdy = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", rspv, 1);
      check("bp_p", rspp, 24);
      check("bp_id", rspid, 0);
      check("bp_ready1", r1r, 0);
      check("bp_ready0", r0r, 0);
      tick();
    end
    rsprdy = 1'b1;
    #1;
    check("bp_hs_ready1", r1r, 0);
    tick();
    check("bp_req1_accept", r1r, 1);
    tick();
    r1v = 1'b0;
    for (int i = 0; i < S1; i++) tick();
    check("bp_req1_valid", rspv, 1);
    check("bp_req1_p", rspp, 25);
    check("bp_req1_id", rspid, 1);
    tick();

    // Reset pulse during SETTLE of a req0 operation
    r0v = 1'b1; r0a = 4'd8; r0b = 4'd8;
    #1;
    check("rp_accept", r0r, 1);
    tick();
    r0v = 1'b0;
    check("rp_in_settle", ma, 8);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rp_no_rsp", rspv, 0);
    end
    check("rp_mul_a", ma, 0);
    check("rp_mul_b", mb, 0);
    check("rp_rsp_p", rspp, 0);
    check("rp_rsp_id", rspid, 0);
    // last_grant is back at its reset value, so req0 wins the first tie
    r0v = 1'b1; r1v = 1'b1;
    #1;
    check("rp_tie_ready0", r0r, 1);
    check("rp_tie_ready1", r1r, 0);
    r0v = 1'b0; r1v = 1'b0;
    tick();
    op1(1'b1, 4'd2, 4'd2, 8'd4);

    // S=4: exact latency, then exhaustive sweep
    r0v4 = 1'b1; r0a4 = 4'd12; r0b4 = 4'd13;
    #1;
    check("s4_accept", r0r4, 1);
    tick();
    r0v4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("s4_settle_valid", rspv4, 0);
      tick();
    end
    check("s4_rsp_valid_c5", rspv4, 1);
    check("s4_rsp_p", rspp4, 156);
    tick();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        prod = 8'(a * b);
        op4(1'(a ^ b), 4'(a), 4'(b), prod);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
